rc4_result_collector: RTL
=========================

# rc4_result_collector

Consumes the status of the parallel `rc4_cracker` cores and produces one system-level search result. It sits directly downstream of the cores and upstream of the LEDR/HEX display logic.

- Detects the start press and sequences the run.
- Arbitrates simultaneous finds, latches the winning key and core index, and broadcasts `stop` to all cores.
- Declares exhaustion when every core has failed.
- Counts pause-aware elapsed cycles for throughput measurement.

## Interface
Parameters:
- NUM_CORES, 4, number of cracker cores monitored (≥1)
- KEY_W, 24, key width per core
- CNT_W, 32, elapsed-cycle counter width
- IDX_W, $clog2(NUM_CORES) (min 1), width of win_index

Ports:
- clk  in  1  system clock; one clock, all logic on its rising edge
- reset_n  in  1  reset is asynchronous and active-low
- start  in  1  active-high start level (already inverted from KEY[0])
- pause  in  1  active-high pause level
- core_ready  in  NUM_CORES  per-core ready
- core_finish  in  NUM_CORES  per-core key-found flag (level)
- core_failure  in  NUM_CORES  per-core range-exhausted flag (level)
- core_key  in  NUM_CORES*KEY_W  per-core current key; core i occupies bits [i*KEY_W +: KEY_W]
- stop  out  1  registered; instructs all cores to halt
- busy  out  1  high in RUN
- found  out  1  high in FOUND
- exhausted  out  1  high in EXHAUSTED
- win_key  out  KEY_W  latched winning key
- win_index  out  IDX_W  winning core index
- win_onehot  out  NUM_CORES  winning core, one-hot
- display_key  out  KEY_W  key for the HEX display
- elapsed  out  CNT_W  run cycle count, saturating

## Operation
- States: IDLE, RUN, FOUND, EXHAUSTED. All outputs are registered except `display_key`.
- Start edge: `start_q` is a register of `start`.
  - `start_rise = start & ~start_q`.
  - `start_q` resets to 1, so a start held through reset does not trigger a run.
- IDLE / FOUND / EXHAUSTED:
  - On `start_rise` with all `core_ready` high, go to RUN.
  - On that edge, clear `found`, `exhausted`, `stop`, `win_*` and `elapsed`.
  - `start_rise` while any core is not ready is ignored and not remembered.
- RUN, evaluated each edge in this priority order:
  1. Any `core_finish` set: the lowest set index i wins. Go to FOUND. Latch `win_key` = core_key[i], `win_index` = i, `win_onehot` = 1<<i, and set `stop` = 1.
  2. All `core_failure` set: go to EXHAUSTED and set `stop` = 1. `win_*` stay 0.
  3. Otherwise, if `pause` = 0, `elapsed` increments, saturating at all-ones. If `pause` = 1, `elapsed` holds.
- A finish and the final failure on the same edge resolve to FOUND.
- `start_rise` during RUN is ignored.
- `elapsed` does not increment on the terminal edge and holds afterwards.
- `stop` stays high in FOUND and EXHAUSTED until the next accepted start.
- `display_key` is combinational: `win_key` in FOUND, otherwise core_key[0] (live progress).
- Reset (asynchronous, any state):
  - State goes to IDLE and `start_q` to 1.
  - `stop`, `busy`, `found`, `exhausted`, `win_key`, `win_index`, `win_onehot` and `elapsed` all go to 0.
  - `display_key` then follows core_key[0].

## Timing
- Start: a rising edge of `start` sampled at edge E causes `busy` = 1 and `elapsed` = 0 after E.
- Find / fail latency: `core_finish` or the last `core_failure` sampled high at edge T causes `found`/`exhausted`, `stop` and `win_*` to be valid after T, i.e. one cycle.
- Cores see `stop` one cycle after their finish flag. Flags from other cores arriving after T are ignored.
- Elapsed count: `elapsed` equals the number of RUN edges, excluding the entry and terminal edges, on which `pause` was 0.
  - Finish first sampled at the Nth edge after entry, with no pause, gives `elapsed` = N−1.
- Inputs are assumed synchronous to `clk`; button synchronisation/debounce happens upstream.

## Test plan
1. Reset with `start` held high, then release reset:
   - All outputs are 0 and state is IDLE.
   - No run starts until `start` goes low then high.
2. Start with all ready; raise `core_finish[2]` with core_key[2] = 0x1ABCDE on the 101st edge after entry, no pause:
   - `found` = 1, `win_index` = 2, `win_onehot` = 4'b0100.
   - `win_key` = `display_key` = 0x1ABCDE, `stop` = 1, `elapsed` = 100.
3. Raise `core_finish[1]` and `core_finish[3]` on the same edge:
   - `win_index` = 1, `win_onehot` = 4'b0010, `win_key` = core_key[1].
   - A later `core_finish[0]` does not change the result.
4. Raise failures staggered on cores 0, 2, 3, then 1:
   - `exhausted` = 1 one cycle after core 1 fails; `stop` = 1; `win_*` = 0.
   - Repeat with `core_finish[1]` on the same edge as the last failure: `found` = 1, `win_index` = 1.
5. Hold `pause` high for 30 cycles mid-run, finish at edge 101:
   - `elapsed` = 70.
   - With CNT_W = 4 and a 40-cycle run: `elapsed` saturates at 15.
6. Assert `reset_n` low mid-RUN, between clock edges:
   - Outputs clear immediately without waiting for a clock edge.
   - Also verify: a `start_rise` while `core_ready` = 4'b1011 is ignored (stays IDLE), and a second `start_rise` from FOUND clears the result and re-enters RUN.

Source files
------------

// File: rtl/rc4_result_collector.sv
// Collects per-core status from the rc4_cracker array into one search result:
// start sequencing, lowest-index find arbitration, exhaustion and elapsed count.
module rc4_result_collector #(
    parameter int NUM_CORES = 4,
    parameter int KEY_W     = 24,
    parameter int CNT_W     = 32,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       pause,
    input  logic [NUM_CORES-1:0]       core_ready,
    input  logic [NUM_CORES-1:0]       core_finish,
    input  logic [NUM_CORES-1:0]       core_failure,
    input  logic [NUM_CORES*KEY_W-1:0] core_key,
    output logic                       stop,
    output logic                       busy,
    output logic                       found,
    output logic                       exhausted,
    output logic [KEY_W-1:0]           win_key,
    output logic [IDX_W-1:0]           win_index,
    output logic [NUM_CORES-1:0]       win_onehot,
    output logic [KEY_W-1:0]           display_key,
    output logic [CNT_W-1:0]           elapsed
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        FOUND     = 2'd2,
        EXHAUSTED = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_start_q;
    logic                   r_stop;
    logic                   r_busy;
    logic                   r_found;
    logic                   r_exhausted;
    logic [KEY_W-1:0]       r_win_key;
    logic [IDX_W-1:0]       r_win_index;
    logic [NUM_CORES-1:0]   r_win_onehot;
    logic [CNT_W-1:0]       r_elapsed;

    logic                   w_start_rise;
    logic                   w_all_ready;
    logic                   w_any_finish;
    logic                   w_all_fail;
    logic [IDX_W-1:0]       w_fin_idx;
    logic [KEY_W-1:0]       w_fin_key;
    logic [NUM_CORES-1:0]   w_fin_onehot;

    assign w_start_rise = start & ~r_start_q;
    assign w_all_ready  = &core_ready;
    assign w_any_finish = |core_finish;
    assign w_all_fail   = &core_failure;

    // Scan from the top down so the lowest set finish index is the last write.
    always_comb begin
        w_fin_idx    = '0;
        w_fin_key    = '0;
        w_fin_onehot = '0;
        for (int unsigned i = NUM_CORES; i > 0; i--) begin
            if (core_finish[i-1]) begin
                w_fin_idx           = IDX_W'(i - 1);
                w_fin_key           = core_key[(i-1)*KEY_W +: KEY_W];
                w_fin_onehot        = '0;
                w_fin_onehot[i-1]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_start_q    <= 1'b1;
            r_stop       <= 1'b0;
            r_busy       <= 1'b0;
            r_found      <= 1'b0;
            r_exhausted  <= 1'b0;
            r_win_key    <= '0;
            r_win_index  <= '0;
            r_win_onehot <= '0;
            r_elapsed    <= '0;
        end else begin
            r_start_q <= start;
            case (r_state)
                RUN: begin
                    if (w_any_finish) begin
                        r_state      <= FOUND;
                        r_busy       <= 1'b0;
                        r_found      <= 1'b1;
                        r_stop       <= 1'b1;
                        r_win_key    <= w_fin_key;
                        r_win_index  <= w_fin_idx;
                        r_win_onehot <= w_fin_onehot;
                    end else if (w_all_fail) begin
                        r_state     <= EXHAUSTED;
                        r_busy      <= 1'b0;
                        r_exhausted <= 1'b1;
                        r_stop      <= 1'b1;
                    end else if (!pause && (r_elapsed != '1)) begin
                        r_elapsed <= r_elapsed + 1'b1;
                    end
                end
                default: begin
                    if (w_start_rise && w_all_ready) begin
                        r_state      <= RUN;
                        r_busy       <= 1'b1;
                        r_found      <= 1'b0;
                        r_exhausted  <= 1'b0;
                        r_stop       <= 1'b0;
                        r_win_key    <= '0;
                        r_win_index  <= '0;
                        r_win_onehot <= '0;
                        r_elapsed    <= '0;
                    end
                end
            endcase
        end
    end

    assign stop        = r_stop;
    assign busy        = r_busy;
    assign found       = r_found;
    assign exhausted   = r_exhausted;
    assign win_key     = r_win_key;
    assign win_index   = r_win_index;
    assign win_onehot  = r_win_onehot;
    assign elapsed     = r_elapsed;
    assign display_key = (r_state == FOUND) ? r_win_key : core_key[KEY_W-1:0];

endmodule
